// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_run_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

    // I/O address whose write marks the end of the program
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0003_0004;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// CPU I/O write bus as seen by the run controller.
interface sim_run_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  io_wr;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [7:0]            io_data;

    modport master (output io_wr, output io_addr, output io_data);
    modport slave  (input  io_wr, input  io_addr, input  io_data);
endinterface

// File: rtl/sim_run_ctrl_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on clk.
module reset_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);
    logic [1:0] r_sync;

    // Shift zeros in once rst is released; force ones while it is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], 1'b0};
    end

    assign rst_sync = r_sync[1];
endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: stretches CPU reset, counts run cycles, detects the halt
// write, drains the UART before done and stops on a cycle-limit timeout.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned          RST_CYCLES   = 5,
    parameter int unsigned          MAX_CYCLES   = 150000000,
    parameter int unsigned          DRAIN_CYCLES = 2000,
    parameter int unsigned          CNT_WIDTH    = 32,
    parameter int unsigned          ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = ADDR_WIDTH'(HALT_ADDR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    sim_run_ctrl_if.slave        io,
    output logic                 cpu_rst,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic                 done,
    output logic                 timeout,
    output logic [7:0]           exit_code
);
    localparam int unsigned PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned PH_W   = cnt_bits(PH_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [PH_W-1:0]      PH_HOLD  = PH_W'(RST_CYCLES);
    localparam logic [PH_W-1:0]      PH_DRAIN = PH_W'(DRAIN_CYCLES - 1);

    run_state_e           r_state;
    run_state_e           w_next;
    logic [PH_W-1:0]      r_phase;
    logic [PH_W-1:0]      w_phase_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [7:0]           w_exit_nxt;
    logic                 w_rst_sync;
    logic                 w_halt;

    reset_sync u_reset_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (w_rst_sync)
    );

    assign w_halt = io.io_wr && (io.io_addr == HALT_ADDR);

    // Next-state and next-value logic; the shared phase counter times both
    // the reset hold and the UART drain
    always_comb begin
        w_next      = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = cycle_cnt;
        w_exit_nxt  = exit_code;
        case (r_state)
            ST_HOLD: begin
                if (!w_rst_sync) begin
                    if (r_phase == PH_HOLD) begin
                        w_next      = ST_RUN;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PH_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (cycle_cnt != CNT_SAT) w_cnt_nxt = cycle_cnt + CNT_WIDTH'(1);
                if (w_halt) begin
                    w_exit_nxt = io.io_data;
                    w_next     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else if ((MAX_CYCLES != 0) && (cycle_cnt == CNT_LAST)) begin
                    w_next = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (r_phase == PH_DRAIN) w_next = ST_DONE;
                else                     w_phase_nxt = r_phase + PH_W'(1);
            end
            ST_DONE, ST_TIMEOUT: w_next = r_state;
            default: w_next = ST_HOLD;
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_HOLD;
            r_phase   <= '0;
            cycle_cnt <= '0;
            exit_code <= '0;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_phase   <= w_phase_nxt;
            cycle_cnt <= w_cnt_nxt;
            exit_code <= w_exit_nxt;
            cpu_rst   <= !((w_next == ST_RUN) || (w_next == ST_DRAIN));
            running   <= (w_next == ST_RUN);
            done      <= (w_next == ST_DONE);
            timeout   <= (w_next == ST_TIMEOUT);
        end
    end
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomised bench for sim_run_ctrl: three configurations share one I/O bus,
// each with its own reset; expected outputs come from a closed-form model.
module tb_sim_run_ctrl;
    import sim_run_ctrl_pkg::*;

    localparam logic [31:0] HALT = 32'h0003_0004;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    int         sel = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    int unsigned cfg_r [3] = '{5, 5, 2};
    int unsigned cfg_m [3] = '{1000, 50, 0};
    int unsigned cfg_d [3] = '{16, 16, 0};
    int unsigned cfg_w [3] = '{32, 32, 4};

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    logic        a_cpu_rst, a_run, a_done, a_to;
    logic [31:0] a_cnt;
    logic [7:0]  a_ec;
    logic        b_cpu_rst, b_run, b_done, b_to;
    logic [31:0] b_cnt;
    logic [7:0]  b_ec;
    logic        c_cpu_rst, c_run, c_done, c_to;
    logic [3:0]  c_cnt;
    logic [7:0]  c_ec;

    sim_run_ctrl #(.RST_CYCLES(5), .MAX_CYCLES(1000), .DRAIN_CYCLES(16), .CNT_WIDTH(32), .ADDR_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst_v[0]), .io(bus.slave), .cpu_rst(a_cpu_rst), .running(a_run),
        .cycle_cnt(a_cnt), .done(a_done), .timeout(a_to), .exit_code(a_ec));
    sim_run_ctrl #(.RST_CYCLES(5), .MAX_CYCLES(50), .DRAIN_CYCLES(16), .CNT_WIDTH(32), .ADDR_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst_v[1]), .io(bus.slave), .cpu_rst(b_cpu_rst), .running(b_run),
        .cycle_cnt(b_cnt), .done(b_done), .timeout(b_to), .exit_code(b_ec));
    sim_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(0), .DRAIN_CYCLES(0), .CNT_WIDTH(4), .ADDR_WIDTH(32)) dut_c (
        .clk(clk), .rst(rst_v[2]), .io(bus.slave), .cpu_rst(c_cpu_rst), .running(c_run),
        .cycle_cnt(c_cnt), .done(c_done), .timeout(c_to), .exit_code(c_ec));

    logic        o_cpu_rst, o_run, o_done, o_to;
    logic [31:0] o_cnt;
    logic [7:0]  o_ec;

    // Route the selected DUT's outputs to the checker
    always_comb begin
        o_cpu_rst = a_cpu_rst; o_run = a_run; o_done = a_done;
        o_to = a_to; o_cnt = a_cnt; o_ec = a_ec;
        case (sel)
            1: begin
                o_cpu_rst = b_cpu_rst; o_run = b_run; o_done = b_done;
                o_to = b_to; o_cnt = b_cnt; o_ec = b_ec;
            end
            2: begin
                o_cpu_rst = c_cpu_rst; o_run = c_run; o_done = c_done;
                o_to = c_to; o_cnt = {28'd0, c_cnt}; o_ec = c_ec;
            end
            default: ;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got 0x%0h, want 0x%0h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph, input logic e_cpu_rst, input logic e_run,
                                 input logic [31:0] e_cnt, input logic e_done,
                                 input logic e_to, input logic [7:0] e_ec);
        check_val({ph, ".cpu_rst"},   32'(o_cpu_rst), 32'(e_cpu_rst));
        check_val({ph, ".running"},   32'(o_run),     32'(e_run));
        check_val({ph, ".cycle_cnt"}, o_cnt,          e_cnt);
        check_val({ph, ".done"},      32'(o_done),    32'(e_done));
        check_val({ph, ".timeout"},   32'(o_to),      32'(e_to));
        check_val({ph, ".exit_code"}, 32'(o_ec),      32'(e_ec));
    endtask

    // Edge (counted from reset release) at which RUN is left; huge if never
    function automatic longint exit_edge(input int d, input int unsigned h);
        longint s = 3 + longint'(cfg_r[d]);
        if (h != 0 && (cfg_m[d] == 0 || h <= cfg_m[d])) return s + longint'(h);
        if (cfg_m[d] != 0) return s + longint'(cfg_m[d]);
        return 64'd1 << 40;
    endfunction

    // Expected outputs after edge n of a run that halts on RUN cycle h (0 = never)
    task automatic model(input int d, input longint n, input int unsigned h, input logic [7:0] data,
                         output logic e_cpu_rst, output logic e_run, output logic [31:0] e_cnt,
                         output logic e_done, output logic e_to, output logic [7:0] e_ec);
        longint s    = 3 + longint'(cfg_r[d]);
        longint sat  = (64'd1 << cfg_w[d]) - 1;
        longint x    = exit_edge(d, h);
        bit     halt = (h != 0) && (cfg_m[d] == 0 || h <= cfg_m[d]);
        longint c;
        e_cpu_rst = 1'b1; e_run = 1'b0; e_cnt = '0; e_done = 1'b0; e_to = 1'b0; e_ec = '0;
        if (n < s) return;
        if (n < x) begin
            c = n - s;
            e_cpu_rst = 1'b0; e_run = 1'b1; e_cnt = 32'((c > sat) ? sat : c);
        end else if (halt) begin
            e_cnt = 32'((longint'(h) > sat) ? sat : longint'(h));
            e_ec  = data;
            if (n < x + longint'(cfg_d[d])) e_cpu_rst = 1'b0;
            else                            e_done = 1'b1;
        end else begin
            c = longint'(cfg_m[d]);
            e_cnt = 32'((c > sat) ? sat : c);
            e_to  = 1'b1;
        end
    endtask

    // One reset-release run on DUT d; abort_n != 0 re-asserts rst after that edge
    task automatic run_trial(input int d, input int unsigned h, input logic [7:0] data,
                             input int unsigned abort_n);
        longint s = 3 + longint'(cfg_r[d]);
        longint x = exit_edge(d, h);
        longint end_n;
        logic e_cpu_rst, e_run, e_done, e_to;
        logic [31:0] e_cnt;
        logic [7:0]  e_ec;
        end_n = (abort_n != 0) ? longint'(abort_n) : x + longint'(cfg_d[d]) + 4;
        sel = d;
        @(negedge clk);
        rst_v[d] = 1'b1;
        bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_data = '0;
        #1 check_outputs("async_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        check_outputs("in_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
        rst_v[d] = 1'b0;
        for (longint n = 1; n <= end_n; n++) begin
            longint m = n - 1;
            bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_data = 8'($urandom);
            if (h != 0 && m == s + longint'(h) - 1) begin
                bus.io_wr = 1'b1; bus.io_addr = HALT; bus.io_data = data;
            end else if ($urandom_range(3) == 0) begin
                bus.io_wr = 1'b1;
                if (m < s || m >= x) begin
                    bus.io_addr = HALT; bus.io_data = 8'h55;
                end else begin
                    bus.io_addr = HALT ^ (32'd1 << $urandom_range(31));
                end
            end
            @(posedge clk);
            @(negedge clk);
            model(d, n, h, data, e_cpu_rst, e_run, e_cnt, e_done, e_to, e_ec);
            check_outputs("run", e_cpu_rst, e_run, e_cnt, e_done, e_to, e_ec);
            check_val("done_and_timeout", 32'(o_done & o_to), 32'd0);
        end
        bus.io_wr = 1'b0;
        if (abort_n != 0) begin
            rst_v[d] = 1'b1;
            #1 check_outputs("abort_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
        end
    endtask

    initial begin
        bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_data = '0;
        repeat (10) @(negedge clk);
        run_trial(0, 100, 8'h2A, 0);          // halt after 100 run cycles
        run_trial(1, 0,   8'h00, 0);          // timeout at 50
        run_trial(1, 50,  8'h77, 0);          // halt and timeout tie: halt wins
        run_trial(1, 51,  8'h11, 0);          // halt write after timeout ignored
        run_trial(0, 40,  8'h3C, 8 + 40 + 6); // reset pulsed during drain
        run_trial(0, 20,  8'h5A, 0);          // full sequence after abort
        run_trial(2, 30,  8'h99, 0);          // 4-bit counter saturates, no drain
        run_trial(2, 3,   8'h01, 0);
        run_trial(2, 30,  8'hA5, 3);          // reset pulsed during hold
        repeat (12) begin
            int d = $urandom_range(2);
            int unsigned h = (d == 1) ? $urandom_range(70) : $urandom_range(120, 1);
            int unsigned ab = 0;
            if ($urandom_range(3) == 0)
                ab = $urandom_range(32'(exit_edge(d, h)) + cfg_d[d] + 2, 1);
            run_trial(d, h, 8'($urandom), ab);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
